// File: rtl/cache_request_gen_pkg.sv
// Shared definitions for the cache requester: state encoding and the default
// address width used by the controller and datapath.
package cache_request_gen_pkg;

  localparam int unsigned CRG_ADDR_W = 15;
  localparam int unsigned STATE_W    = 3;

  localparam logic [STATE_W-1:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [STATE_W-1:0] ST_ISSUE_ENC  = 3'd1;
  localparam logic [STATE_W-1:0] ST_SAMPLE_ENC = 3'd2;
  localparam logic [STATE_W-1:0] ST_WAIT_ENC   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE_ENC   = 3'd4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_ISSUE  = ST_ISSUE_ENC,
    ST_SAMPLE = ST_SAMPLE_ENC,
    ST_WAIT   = ST_WAIT_ENC,
    ST_DONE   = ST_DONE_ENC
  } state_e;

endpackage

// File: rtl/cache_request_gen_watchdog.sv
// Handshake watchdog: counts consecutive stalled cycles and flags the
// TIMEOUT-th one; cleared by a new run or any non-stalled cycle.
module req_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_c_o
);

  localparam int unsigned     WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] LAST = WD_W'(TIMEOUT - 1);

  logic [WD_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Saturate at LAST so a master that ignores the flag never wraps back to idle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !count_en_i) cnt_d = '0;
    else if (cnt_q != LAST)     cnt_d = cnt_q + WD_W'(1);
  end

  assign expired_c_o = count_en_i && !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/cache_request_gen.sv
// Requester-side sequencer: issues NUM_REQ sequential reads from BASE_ADDR over
// the start/Ready handshake and counts hits and completed requests.
module cache_request_gen
  import cache_request_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = CRG_ADDR_W,
  parameter int unsigned BASE_ADDR = 1024,
  parameter int unsigned NUM_REQ   = 8192,
  parameter int unsigned CNT_W     = 14,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic              Ready,
  input  logic              HMbar,
  output logic              start,
  output logic [ADDR_W-1:0] address,
  output logic [CNT_W:0]    hit_cnt,
  output logic [CNT_W:0]    req_cnt,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int unsigned CW = CNT_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CW-1:0]     hit_q, hit_d;
  logic [CW-1:0]     req_q, req_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_c;
  logic              go_acc_c;
  logic              wd_count_c;
  logic              wd_expired_c;

  assign wd_count_c = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && !Ready;

  req_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (go_acc_c),
    .count_en_i (wd_count_c),
    .expired_c_o(wd_expired_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= ADDR_W'(BASE_ADDR);
      hit_q   <= '0;
      req_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hit_q   <= hit_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    hit_d    = hit_q;
    req_d    = req_q;
    err_d    = err_q;
    start_c  = 1'b0;
    go_acc_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (go) begin
          go_acc_c = 1'b1;
          state_d  = ST_ISSUE;
          addr_d   = ADDR_W'(BASE_ADDR);
          hit_d    = '0;
          req_d    = '0;
          err_d    = 1'b0;
        end
      end
      ST_ISSUE: begin
        if (wd_expired_c) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (Ready) begin
          start_c = 1'b1;
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        hit_d   = hit_q + CW'(HMbar);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wd_expired_c) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else if (Ready) begin
          req_d = req_q + CW'(1);
          if (req_q == CW'(NUM_REQ - 1)) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + ADDR_W'(1);
            state_d = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d == ST_ISSUE) || (state_d == ST_SAMPLE) || (state_d == ST_WAIT);
    done_d = (state_d == ST_DONE);
  end

  // start must qualify with Ready in the same cycle, so it is decoded, not registered.
  assign start   = start_c;
  assign address = addr_q;
  assign hit_cnt = hit_q;
  assign req_cnt = req_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = err_q;

endmodule

// File: doc/cache_request_gen.md
Name: cache_request_gen

Overview:
Requester-side sequencer for the cache controller's start/Ready/address handshake. It issues a run of sequential read addresses from a base address, drives start/address one request at a time, and samples the hit indication per request. It keeps hit and request counts for hit-rate evaluation, and sits between the testbench or CPU-side top level and the cache controller plus datapath.

Parameters:
ADDR_W, 15, address width; matches the cache address bus.
BASE_ADDR, 1024, first address of a run.
NUM_REQ, 8192, requests per run; must be at least 1.
CNT_W, 14, counter width; must satisfy 2^CNT_W >= NUM_REQ.
TIMEOUT, 64, maximum cycles Ready may stay low per request before error is raised.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
go  input  1  level-sampled run request, honoured only in IDLE or DONE.
Ready  input  1  controller idle/accepting indication.
HMbar  input  1  controller hit(1)/miss(0), valid in the first cycle after start is accepted.
start  output  1  one-cycle request pulse to the controller.
address  output  ADDR_W  current request address, stable from start until Ready returns high.
hit_cnt  output  CNT_W+1  number of hits in the current or last run.
req_cnt  output  CNT_W+1  number of completed requests.
busy  output  1  high from go acceptance until DONE.
done  output  1  high while in DONE.
error  output  1  sticky timeout flag; cleared by rst or by a new go.

Behaviour:
- Reset (asynchronous, applies immediately): state IDLE; start=0, address=BASE_ADDR, hit_cnt=0, req_cnt=0, busy=0, done=0, error=0, watchdog=0.
- States: IDLE, ISSUE, SAMPLE, WAIT, DONE.
- IDLE: on go=1, go to ISSUE. Load address=BASE_ADDR, clear counters and error, set busy=1.
- ISSUE: if Ready=1, assert start=1 for this cycle and go to SAMPLE. If Ready=0, hold start=0 and stay; the watchdog counts.
- SAMPLE: start=0. Add HMbar to hit_cnt. Go to WAIT. HMbar is sampled here only, never in WAIT.
- WAIT: stay while Ready=0. When Ready=1: increment req_cnt. If req_cnt was NUM_REQ-1, go to DONE with busy=0 and done=1. Otherwise increment address and go to ISSUE.
- DONE: hold counters and the last address. A go=1 restarts exactly as from IDLE.
- Per-request latency with the current controller: hit = 4 cycles (ISSUE, SAMPLE, WAIT/Ready=0, WAIT/Ready=1); miss = 5 cycles.
- Address arithmetic: ADDR_W-bit increment, modulo 2^ADDR_W on wrap. No saturation.
- Watchdog:
  - Counts consecutive cycles in ISSUE or WAIT with Ready=0; resets whenever Ready=1.
  - When it reaches TIMEOUT: set error=1, force DONE, busy=0, done=1. Counters keep their partial values.
- go asserted while busy: ignored.
- go held high in DONE: starts a new run every time DONE is re-entered.
- start is never asserted outside ISSUE. At most one request is outstanding.
- hit_cnt <= req_cnt+1 holds at all times; miss count = req_cnt - hit_cnt is derived externally.

Decomposition:
- Shared package: state encoding (3-bit localparams for IDLE/ISSUE/SAMPLE/WAIT/DONE) and the default ADDR_W shared with the controller and datapath.
- One natural sub-module: req_watchdog (load/clear, count enable, terminal flag), reusable by other handshake masters.
- FSM, address register and counters stay in the top module.

Test Plan:
- NUM_REQ=4, BASE_ADDR=1024, model always hits -> addresses 1024..1027, each start exactly one cycle, hit_cnt=4, req_cnt=4, done after 16 cycles.
- NUM_REQ=4, model misses on even addresses -> hit_cnt=2, req_cnt=4, run length 18 cycles.
- Ready held low 5 cycles after go -> start withheld until Ready=1; address stays 1024; no counter change.
- Model stalls Ready low with TIMEOUT=8 -> error=1 after 8 cycles, done=1, req_cnt frozen at its partial value.
- rst pulsed mid-run in WAIT -> outputs immediately at reset values; next go restarts at 1024 with zero counts.
- BASE_ADDR=32766, NUM_REQ=3 -> addresses 32766, 32767, 0.
